// File: rtl/wb_motor_ramp.sv
// Wishbone-controlled duty ramp generator feeding a four-channel PWM block.
// Each live duty slews toward its CPU-written target by STEP once per ramp
// tick. Disarming or a command-watchdog timeout ramps all channels to zero
// before the PWM enable drops.
module wb_motor_ramp #(
    parameter int bit_resolution = 8,
    parameter int tick_div       = 1000,
    parameter int wdt_ticks      = 250
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_stb_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_we_i,
    input  logic [31:0]               wb_adr_i,
    input  logic [3:0]                wb_sel_i,
    input  logic [31:0]               wb_dat_i,
    output logic [31:0]               wb_dat_o,
    output logic                      wb_ack_o,
    output logic [bit_resolution-1:0] duty0,
    output logic [bit_resolution-1:0] duty1,
    output logic [bit_resolution-1:0] duty2,
    output logic [bit_resolution-1:0] duty3,
    output logic                      ena_out,
    output logic                      failsafe_o
);

    localparam int presc_w = (tick_div > 1) ? $clog2(tick_div) : 1;
    localparam int wdt_w   = (wdt_ticks > 0) ? $clog2(wdt_ticks + 1) : 1;
    localparam logic [presc_w-1:0] presc_last = presc_w'(tick_div - 1);
    localparam logic [wdt_w-1:0]   wdt_last   = wdt_w'((wdt_ticks > 0) ? wdt_ticks - 1 : 0);

    typedef logic [bit_resolution-1:0] val_t;

    logic               ack;
    logic [31:0]        dat_q;
    logic [presc_w-1:0] presc;
    logic               tick;
    logic [wdt_w-1:0]   wdt;
    logic               arm;
    logic               failsafe;
    logic               ena;
    val_t               step;
    val_t               step_eff;
    val_t               target    [4];
    val_t               duty      [4];
    val_t               duty_next [4];

    logic               access;
    logic               wr;
    logic [3:0]         idx;
    logic               wr_ctrl;
    logic               wr_step;
    logic               wr_tgt;
    logic [1:0]         tgt_sel;
    val_t               wr_val;
    logic               refresh;
    logic               expire;
    logic               all_zero;
    logic               busy;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    assign access  = wb_stb_i & wb_cyc_i & ~ack;
    assign idx     = wb_adr_i[5:2];
    assign wr      = access & wb_we_i;
    assign wr_ctrl = wr & (idx == 4'd0);
    assign wr_step = wr & (idx == 4'd1);
    assign wr_tgt  = wr & (idx >= 4'd2) & (idx <= 4'd5);
    assign tgt_sel = 2'(idx - 4'd2);
    assign wr_val  = wb_dat_i[bit_resolution-1:0];

    // A target write, or an arm request that will be honoured, restarts the
    // watchdog and takes priority over an expiry landing on the same edge.
    assign refresh = wr_tgt | (wr_ctrl & wb_dat_i[0] & ~failsafe);
    assign tick    = (presc == presc_last);
    assign expire  = tick & arm & ~refresh & (wdt_ticks != 0) & (wdt == wdt_last);

    assign step_eff = (step == '0) ? val_t'(1) : step;

    assign unused_bits = &{1'b0, wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i};

    // Next duty per channel: step toward target with one guard bit, clamp at target.
    always_comb begin
        logic [bit_resolution:0] up;
        logic [bit_resolution:0] dn;
        up = '0;
        dn = '0;
        for (int i = 0; i < 4; i++) begin
            up = {1'b0, duty[i]} + {1'b0, step_eff};
            dn = {1'b0, duty[i]} - {1'b0, step_eff};
            duty_next[i] = duty[i];
            if (duty[i] < target[i]) begin
                duty_next[i] = (up > {1'b0, target[i]}) ? target[i] : up[bit_resolution-1:0];
            end else if (duty[i] > target[i]) begin
                duty_next[i] = (dn[bit_resolution] || (dn[bit_resolution-1:0] < target[i]))
                             ? target[i] : dn[bit_resolution-1:0];
            end
        end
    end

    // Channel status used by the enable drop-out and the CTRL busy bit.
    always_comb begin
        all_zero = 1'b1;
        busy     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (duty[i] != '0)        all_zero = 1'b0;
            if (duty[i] != target[i]) busy     = 1'b1;
        end
    end

    // Register read mux; unused upper bits read as zero.
    always_comb begin
        rd_mux = 32'd0;
        case (idx)
            4'd0:    rd_mux = {29'd0, busy, failsafe, arm};
            4'd1:    rd_mux = 32'(step);
            4'd2:    rd_mux = 32'(target[0]);
            4'd3:    rd_mux = 32'(target[1]);
            4'd4:    rd_mux = 32'(target[2]);
            4'd5:    rd_mux = 32'(target[3]);
            4'd6:    rd_mux = 32'(duty[0]);
            4'd7:    rd_mux = 32'(duty[1]);
            4'd8:    rd_mux = 32'(duty[2]);
            4'd9:    rd_mux = 32'(duty[3]);
            default: rd_mux = 32'd0;
        endcase
    end

    // Bus handshake, prescaler, ramp, arming and watchdog state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack      <= 1'b0;
            dat_q    <= 32'd0;
            presc    <= '0;
            wdt      <= '0;
            arm      <= 1'b0;
            failsafe <= 1'b0;
            ena      <= 1'b0;
            step     <= '0;
            for (int i = 0; i < 4; i++) begin
                target[i] <= '0;
                duty[i]   <= '0;
            end
        end else begin
            ack   <= access;
            presc <= tick ? '0 : presc + 1'b1;

            if (access && !wb_we_i) dat_q <= rd_mux;

            if (tick) begin
                for (int i = 0; i < 4; i++) duty[i] <= duty_next[i];
            end

            if (!arm && all_zero) ena <= 1'b0;

            if (wr_ctrl) begin
                if (wb_dat_i[1]) failsafe <= 1'b0;
                if (!failsafe) begin
                    if (wb_dat_i[0]) begin
                        arm <= 1'b1;
                        ena <= 1'b1;
                    end else begin
                        arm <= 1'b0;
                        for (int i = 0; i < 4; i++) target[i] <= '0;
                    end
                end
            end

            if (wr_step) step <= wr_val;

            // Targets only follow the CPU while armed; a disarmed write parks zero.
            if (wr_tgt && !failsafe) target[tgt_sel] <= arm ? wr_val : '0;

            if (refresh) begin
                wdt <= '0;
            end else if (tick && arm && (wdt_ticks != 0)) begin
                if (expire) begin
                    failsafe <= 1'b1;
                    arm      <= 1'b0;
                    wdt      <= '0;
                    for (int i = 0; i < 4; i++) target[i] <= '0;
                end else begin
                    wdt <= wdt + 1'b1;
                end
            end
        end
    end

    assign wb_ack_o   = wb_stb_i & wb_cyc_i & ack;
    assign wb_dat_o   = dat_q;
    assign duty0      = duty[0];
    assign duty1      = duty[1];
    assign duty2      = duty[2];
    assign duty3      = duty[3];
    assign ena_out    = ena;
    assign failsafe_o = failsafe;

endmodule

// File: tb/tb_wb_motor_ramp.sv
// Randomised and directed bench for wb_motor_ramp against a rule-level model.
module tb_wb_motor_ramp;

    localparam int BR   = 8;
    localparam int TDIV = 4;
    localparam int WDT  = 8;

    logic          clk = 1'b0;
    logic          clk_on = 1'b1;
    logic          rst = 1'b1;
    logic          wb_stb_i = 1'b0;
    logic          wb_cyc_i = 1'b0;
    logic          wb_we_i = 1'b0;
    logic [31:0]   wb_adr_i = 32'd0;
    logic [3:0]    wb_sel_i = 4'hF;
    logic [31:0]   wb_dat_i = 32'd0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [BR-1:0] duty0, duty1, duty2, duty3;
    logic          ena_out;
    logic          failsafe_o;

    wb_motor_ramp #(.bit_resolution(BR), .tick_div(TDIV), .wdt_ticks(WDT)) dut (
        .clk(clk), .rst(rst),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty3(duty3),
        .ena_out(ena_out), .failsafe_o(failsafe_o)
    );

    always #5 if (clk_on) clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_duty[4];
    int          m_tgt[4];
    int          m_step;
    int          m_cnt;
    int          m_wdt;
    bit          m_arm, m_fs, m_ena;
    bit          p_valid = 1'b0;
    bit          p_we;
    int          p_idx;
    logic [31:0] p_dat;
    logic [31:0] rd_exp;

    function automatic int ramp(input int d, input int t, input int s);
        int se;
        se = (s == 0) ? 1 : s;
        if (d < t) return (d + se > t) ? t : d + se;
        if (d > t) return (d - se < t) ? t : d - se;
        return d;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        bit bsy;
        bsy = 1'b0;
        for (int i = 0; i < 4; i++) if (m_duty[i] != m_tgt[i]) bsy = 1'b1;
        if (idx == 0) return {29'd0, bsy, m_fs, m_arm};
        if (idx == 1) return 32'(m_step);
        if (idx >= 2 && idx <= 5) return 32'(m_tgt[idx-2]);
        if (idx >= 6 && idx <= 9) return 32'(m_duty[idx-6]);
        return 32'd0;
    endfunction

    // One clock of the behavioural rules: a ramp tick every TDIV cycles after
    // reset, at most one bus write committing on this edge, and the watchdog
    // counting ticks since the last refresh while armed.
    always @(posedge clk or negedge rst) begin : mdl
        bit tick, fs0, arm0, drop, refresh, expire, wr;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin m_duty[i] = 0; m_tgt[i] = 0; end
            m_step = 0; m_cnt = 0; m_wdt = 0;
            m_arm = 0; m_fs = 0; m_ena = 0;
            p_valid = 0;
        end else begin
            tick = ((m_cnt % TDIV) == TDIV - 1);
            m_cnt++;
            fs0  = m_fs;
            arm0 = m_arm;
            wr   = p_valid && p_we;
            if (p_valid && !p_we) rd_exp = model_read(p_idx);
            drop = !arm0 && m_duty[0] == 0 && m_duty[1] == 0 && m_duty[2] == 0 && m_duty[3] == 0;
            refresh = (wr && p_idx >= 2 && p_idx <= 5) || (wr && p_idx == 0 && p_dat[0] && !fs0);
            expire  = tick && arm0 && !refresh && (m_wdt + 1 == WDT);
            if (tick) for (int i = 0; i < 4; i++) m_duty[i] = ramp(m_duty[i], m_tgt[i], m_step);
            if (drop) m_ena = 0;
            if (wr) begin
                if (p_idx == 0) begin
                    if (p_dat[1]) m_fs = 0;
                    if (!fs0) begin
                        if (p_dat[0]) begin m_arm = 1; m_ena = 1; end
                        else begin m_arm = 0; for (int i = 0; i < 4; i++) m_tgt[i] = 0; end
                    end
                end else if (p_idx == 1) begin
                    m_step = int'(p_dat[7:0]);
                end else if (p_idx >= 2 && p_idx <= 5) begin
                    if (!fs0) m_tgt[p_idx-2] = arm0 ? int'(p_dat[7:0]) : 0;
                end
            end
            if (refresh) m_wdt = 0;
            else if (tick && arm0) begin
                if (expire) begin
                    m_fs = 1; m_arm = 0; m_wdt = 0;
                    for (int i = 0; i < 4; i++) m_tgt[i] = 0;
                end else m_wdt++;
            end
            p_valid = 0;
        end
    end

    // Every cycle the PWM-facing outputs must match the model.
    always @(negedge clk) begin
        if (rst)
            chk("outs", {duty0, duty1, duty2, duty3, ena_out, failsafe_o},
                {m_duty[0][7:0], m_duty[1][7:0], m_duty[2][7:0], m_duty[3][7:0], m_ena, m_fs});
    end

    // ---------------- bus helpers ----------------
    // Called just after a rising edge; returns just after the ack-clearing edge.
    task automatic bus(input bit we, input int idx, input logic [31:0] d, output logic [31:0] q);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
        wb_adr_i = 32'(idx) << 2;
        wb_dat_i = d;
        p_valid = 1'b1; p_we = we; p_idx = idx; p_dat = d;
        @(negedge clk);
        chk("ack_pre", wb_ack_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("ack", wb_ack_o, 1'b1);
        q = wb_dat_o;
        if (!we) chk("rdata", wb_dat_o, rd_exp);
        @(posedge clk);
        #1;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    int cap_v[$];
    int cap_t[$];

    task automatic capture(input int ncyc, input int start);
        int last;
        last = start;
        cap_v.delete(); cap_t.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (int'(duty0) != last) begin cap_v.push_back(int'(duty0)); cap_t.push_back(i); end
            last = int'(duty0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cap(input string tag, input int n, input int a0, input int a1,
                           input int a2, input int a3, input int a4);
        int e[5];
        e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3; e[4] = a4;
        chk({tag, "_len"}, cap_v.size(), n);
        for (int i = 0; i < n && i < cap_v.size(); i++) begin
            chk(tag, cap_v[i], e[i]);
            if (i > 0 && cap_t[i-1] != 0) chk({tag, "_spacing"}, cap_t[i] - cap_t[i-1], TDIV);
        end
    endtask

    // Waits for ena_out to fall; checks it held while any duty was non-zero
    // and fell exactly one cycle after all duties reached zero.
    task automatic wait_ena_drop(input string tag);
        int  j, jz;
        bit  ena_at_zero, done;
        j = 0; jz = -1; done = 0; ena_at_zero = 0;
        while (j < 100 && !done) begin
            @(negedge clk);
            j++;
            if (jz < 0 && duty0 == 0 && duty1 == 0 && duty2 == 0 && duty3 == 0) begin
                jz = j; ena_at_zero = ena_out;
            end
            if (!ena_out) done = 1;
        end
        chk({tag, "_fell"}, done, 1'b1);
        chk({tag, "_hold"}, ena_at_zero, 1'b1);
        chk({tag, "_lat"}, j - jz, 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] q;
        int          j, r;
        bit          found;

        #1 rst = 1'b0;
        #1;
        chk("reset_outs", {duty0, duty1, duty2, duty3, ena_out, failsafe_o, wb_ack_o}, 35'd0);
        chk("reset_dat", wb_dat_o, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        bus(0, 0, 0, q); chk("reset_ctrl", q, 32'd0);
        bus(0, 1, 0, q); chk("reset_step", q, 32'd0);

        // Ramp up
        bus(1, 0, 32'h1, q);
        bus(1, 1, 32'h10, q);
        bus(1, 2, 32'h40, q);
        bus(0, 0, 0, q); chk("busy_ramp", q, 32'h5);
        capture(18, 0);
        chk_cap("rampup", 4, 'h10, 'h20, 'h30, 'h40, 0);
        bus(0, 0, 0, q); chk("busy_done", q, 32'h1);

        // Clamping both ways
        bus(1, 1, 32'h30, q);
        bus(1, 2, 32'hF0, q);
        capture(18, 'h40);
        chk_cap("clamp_up", 4, 'h70, 'hA0, 'hD0, 'hF0, 0);
        bus(1, 2, 32'h05, q);
        capture(22, 'hF0);
        chk_cap("clamp_dn", 5, 'hC0, 'h90, 'h60, 'h30, 'h05);

        // Watchdog
        bus(1, 3, 32'h80, q);
        j = 0; found = 0;
        while (j < 80 && !found) begin
            @(negedge clk); j++;
            if (failsafe_o) found = 1;
        end
        chk("wdt_fire", found, 1'b1);
        chk("wdt_lat_in_window", (j >= 29 && j <= 32), 1'b1);
        @(posedge clk); #1;
        bus(0, 3, 0, q); chk("wdt_tgt1_cleared", q, 32'd0);
        wait_ena_drop("wdt_ena");
        bus(1, 2, 32'h50, q);
        bus(0, 2, 0, q); chk("fs_tgt_ignored", q, 32'd0);
        bus(1, 0, 32'h3, q);
        chk("fs_cleared", failsafe_o, 1'b0);
        bus(0, 0, 0, q); chk("fs_clear_no_arm", q, 32'd0);
        bus(1, 0, 32'h1, q);
        chk("rearm_ena", ena_out, 1'b1);
        bus(0, 0, 0, q); chk("rearm_ctrl", q, 32'h1);

        // Disarm mid-ramp
        bus(1, 1, 32'h10, q);
        bus(1, 2, 32'h20, q);
        bus(1, 3, 32'h50, q);
        j = 0; found = 0;
        while (j < 40 && !found) begin
            @(negedge clk); j++;
            if (duty1 == 8'h50) found = 1;
        end
        chk("disarm_setup", {found, duty0}, {1'b1, 8'h20});
        @(posedge clk); #1;
        bus(1, 0, 32'h0, q);
        wait_ena_drop("disarm_ena");

        // Bus corner cases
        bus(0, 12, 32'hFFFF_FFFF, q); chk("rd_unmapped", q, 32'd0);
        bus(1, 0, 32'h1, q);
        bus(1, 4, 32'h33, q);
        bus(0, 4, 0, q); chk("b2b_tgt2", q, 32'h33);
        bus(1, 6, 32'hAA, q);
        bus(0, 6, 0, q); chk("duty_ro", q, 32'd0);

        // Async reset with the clock stopped
        bus(1, 5, 32'h90, q);
        idle(10);
        chk("pre_rst_ramp", (duty3 != 0 && duty2 != 0), 1'b1);
        @(negedge clk); #1;
        clk_on = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("async_rst", {duty0, duty1, duty2, duty3, ena_out, failsafe_o}, 34'd0);
        #10 rst = 1'b1;
        #3 clk_on = 1'b1;
        @(posedge clk); #1;

        // Randomised traffic
        bus(1, 0, 32'h1, q);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35) begin
                bus(1, $urandom_range(2, 5), $urandom(), q);
            end else if (r < 45) begin
                j = $urandom_range(0, 9);
                bus(1, 0, {$urandom() & 32'hFFFF_FFFC} | ((j < 6) ? 32'h1 : (j == 6) ? 32'h0 : (j == 7) ? 32'h2 : 32'h3), q);
            end else if (r < 52) begin
                bus(1, 1, ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 64)), q);
            end else if (r < 80) begin
                bus(0, $urandom_range(0, 15), $urandom(), q);
            end else begin
                idle($urandom_range(0, 45));
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
